// File: rtl/ledmtx_pkg.sv
// ledmtx_pkg: shared HUB75 panel geometry and monitor record layout
package ledmtx_pkg;
  localparam int COLS = 32;
  localparam int ROWW = 3;
  localparam int ONW = 16;
  localparam int COLW = $clog2(COLS);
  localparam int RGB_W = 6;
  localparam int ON_LSB = 0;
  localparam int RGB_LSB = ON_LSB + ONW;
  localparam int COL_LSB = RGB_LSB + RGB_W;
  localparam int ROW_LSB = COL_LSB + COLW;
  localparam int REC_W = ROW_LSB + ROWW;
  typedef enum logic {EMIT_IDLE, EMIT_SEND} emit_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: parameterized-width two-flop synchronizer
module sync_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two-stage capture of the asynchronous pins
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/ledmtx_mon.sv
// ledmtx_mon: rebuilds latched HUB75 rows from panel pins and streams them as records
module ledmtx_mon import ledmtx_pkg::*; #(
  parameter int COLS = ledmtx_pkg::COLS,
  parameter int ROWW = ledmtx_pkg::ROWW,
  parameter int ONW = ledmtx_pkg::ONW,
  parameter bit OE_ACTIVE_LOW = 1'b1,
  localparam int COLW = $clog2(COLS),
  localparam int DW = ROWW + COLW + 6 + ONW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWW-1:0] rowaddr,
  input  logic            sclk,
  input  logic            lat,
  input  logic            oe,
  input  logic            r1,
  input  logic            g1,
  input  logic            b1,
  input  logic            r2,
  input  logic            g2,
  input  logic            b2,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  input  logic            sts_clr,
  output logic            ovf,
  output logic            shift_err
);
  localparam int PW = ROWW + 9;
  localparam int ECW = $clog2(COLS + 2);
  logic [PW-1:0] pin_s, pin_p;
  logic sclk_q, lat_q;
  logic [COLS-1:0][5:0] sr, pend_sr, emit_sr;
  logic [ECW-1:0] ecnt;
  logic [ONW-1:0] ontime, emit_on;
  logic [ROWW-1:0] pend_row, emit_row;
  logic [COLW-1:0] col;
  logic pend_v;
  emit_state_t state;
  sync_ff #(.W(PW)) u_sync (
    .clk(clk),
    .rst(rst),
    .d({rowaddr, sclk, lat, oe, r1, g1, b1, r2, g2, b2}),
    .q(pin_s)
  );
  wire [ROWW-1:0] row_p = pin_p[PW-1 -: ROWW];
  wire [5:0] rgb_p = pin_p[5:0];
  wire sclk_rise = pin_p[8] & ~sclk_q;
  wire lat_rise = pin_p[7] & ~lat_q;
  wire on_act = OE_ACTIVE_LOW ? ~pin_p[6] : pin_p[6];
  wire last_col = col == COLW'(COLS - 1);
  wire ovf_set = lat_rise && pend_v && state == EMIT_SEND;
  wire serr_set = lat_rise && ecnt != ECW'(COLS);
  assign m_data = {emit_row, col, emit_sr[col], emit_on};
  assign m_last = m_valid && last_col;
  // edge pipeline, column shifter, shift-edge and on-time counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pin_p <= '0;
      sclk_q <= 1'b0;
      lat_q <= 1'b0;
      sr <= '0;
      ecnt <= '0;
      ontime <= '0;
    end else begin
      pin_p <= pin_s;
      sclk_q <= pin_p[8];
      lat_q <= pin_p[7];
      if (sclk_rise) sr <= {sr[COLS-2:0], rgb_p};
      ecnt <= lat_rise ? '0 : (sclk_rise && ecnt != ECW'(COLS + 1)) ? ecnt + 1'b1 : ecnt;
      ontime <= lat_rise ? '0 : (on_act && ontime != '1) ? ontime + 1'b1 : ontime;
    end
  // pending snapshot on latch, hand-off to the emitter and word sequencing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_v <= 1'b0;
      pend_row <= '0;
      pend_sr <= '0;
      emit_row <= '0;
      emit_sr <= '0;
      emit_on <= '0;
      col <= '0;
      m_valid <= 1'b0;
      state <= EMIT_IDLE;
    end else begin
      if (lat_rise) begin
        pend_v <= 1'b1;
        pend_row <= row_p;
        pend_sr <= sr;
      end
      if (lat_rise && pend_v && state == EMIT_IDLE) begin
        emit_row <= pend_row;
        emit_sr <= pend_sr;
        emit_on <= ontime;
        col <= '0;
        m_valid <= 1'b1;
        state <= EMIT_SEND;
      end else if (state == EMIT_SEND && m_ready) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) begin
          m_valid <= 1'b0;
          state <= EMIT_IDLE;
        end
      end
    end
  // sticky status flags; a same-cycle set beats the clear
  always_ff @(posedge clk or posedge rst)
    if (rst) {ovf, shift_err} <= 2'b00;
    else begin
      ovf <= ovf_set | (ovf & ~sts_clr);
      shift_err <= serr_set | (shift_err & ~sts_clr);
    end
endmodule

// File: tb/tb_ledmtx_mon.sv
// tb_ledmtx_mon: directed and randomized checks of ledmtx_mon against a row-level model
module tb_ledmtx_mon;
  import ledmtx_pkg::*;
  typedef logic [REC_W:0] word_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [ROWW-1:0] rowaddr = '0;
  logic sclk = 1'b0, lat = 1'b0, oe = 1'b1;
  logic r1 = 1'b0, g1 = 1'b0, b1 = 1'b0, r2 = 1'b0, g2 = 1'b0, b2 = 1'b0;
  logic m_ready = 1'b0, ready_val = 1'b1, rand_ready = 1'b0, sts_clr = 1'b0;
  logic m_valid, m_last, ovf, shift_err;
  logic [REC_W-1:0] m_data;
  int tests = 0, fails = 0;
  word_t got_q[$], exp_q[$];
  logic [5:0] msr[$], m_pcols[$];
  int pulses = 0, m_on = 0;
  bit m_pend = 0, e_ovf = 0, e_serr = 0;
  logic [ROWW-1:0] m_prow = '0;
  word_t prev_w, w0, w;
  bit prev_stall = 0;
  ledmtx_mon #(.COLS(COLS), .ROWW(ROWW), .ONW(ONW), .OE_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .rowaddr(rowaddr), .sclk(sclk), .lat(lat), .oe(oe),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sts_clr(sts_clr), .ovf(ovf), .shift_err(shift_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        tests++;
        assert ({m_valid, m_last, m_data} === {1'b1, prev_w})
        else begin
          fails++;
          $error("FAIL hold: got %h want %h", {m_valid, m_last, m_data}, {1'b1, prev_w});
        end
      end
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      prev_stall = m_valid && !m_ready;
      prev_w = {m_last, m_data};
    end
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    msr = {};
    repeat (COLS) msr.push_back(6'd0);
    pulses = 0;
    m_on = 0;
    m_pend = 0;
    e_ovf = 0;
    e_serr = 0;
    exp_q = {};
    got_q = {};
  endtask
  task automatic pulse(logic [5:0] c);
    {r1, g1, b1, r2, g2, b2} = c;
    step(2);
    sclk = 1'b1;
    step(2);
    sclk = 1'b0;
    msr.push_front(c);
    void'(msr.pop_back());
    pulses++;
  endtask
  task automatic rand_row();
    repeat (COLS) pulse(6'($urandom));
  endtask
  task automatic latch(logic [ROWW-1:0] row, bit busy);
    int on;
    rowaddr = row;
    step(2);
    lat = 1'b1;
    step(3);
    lat = 1'b0;
    step(3);
    if (m_pend) begin
      if (busy) e_ovf = 1;
      else begin
        on = (m_on > (1 << ONW) - 1) ? (1 << ONW) - 1 : m_on;
        for (int c = 0; c < COLS; c++)
          exp_q.push_back({1'(c == COLS - 1), m_prow, COLW'(c), m_pcols[c], ONW'(on)});
      end
    end
    m_pend = 1;
    m_prow = row;
    m_pcols = msr;
    m_on = 0;
    if (pulses != COLS) e_serr = 1;
    pulses = 0;
  endtask
  task automatic on_for(int n);
    oe = 1'b0;
    step(n);
    oe = 1'b1;
    m_on += n;
  endtask
  task automatic check_q(string tag);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q = {};
    exp_q = {};
  endtask
  task automatic flags(string tag);
    chk({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    chk({tag, "_serr"}, 64'(shift_err), 64'(e_serr));
  endtask
  task automatic clr();
    sts_clr = 1'b1;
    step();
    sts_clr = 1'b0;
    e_ovf = 0;
    e_serr = 0;
    step(2);
  endtask
  initial begin
    int k;
    model_reset();
    step(3);
    chk("rst_valid", 64'(m_valid), 0);
    chk("rst_last", 64'(m_last), 0);
    chk("rst_data", 64'(m_data), 0);
    flags("rst");
    rst = 1'b0;
    step(2);
    pulse(6'b100000);
    repeat (COLS - 1) pulse(6'b000000);
    latch(3, 0);
    step(3);
    on_for(100);
    step(3);
    rand_row();
    latch(4, 0);
    step(60);
    chk("row3_len", 64'(got_q.size()), COLS);
    if (got_q.size() == COLS) begin
      w = got_q[0];
      chk("row3_row", 64'(w[ROW_LSB +: ROWW]), 3);
      chk("row3_on", 64'(w[ON_LSB +: ONW]), 100);
      chk("row3_r1_c0", 64'(w[RGB_LSB + 5]), 0);
      w = got_q[COLS - 1];
      chk("row3_r1_c31", 64'(w[RGB_LSB + 5]), 1);
      chk("row3_last", 64'(w[REC_W]), 1);
    end
    check_q("row3");
    flags("row3");
    rand_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rand_row();
      latch(ROWW'($urandom), 0);
      step(3);
      on_for($urandom_range(0, 150));
    end
    step(200);
    rand_ready = 1'b0;
    step(2);
    check_q("rand");
    flags("rand");
    repeat (COLS - 1) pulse(6'($urandom));
    latch(5, 0);
    chk("short_serr", 64'(shift_err), 1);
    chk("short_ovf", 64'(ovf), 0);
    step(60);
    check_q("short");
    clr();
    flags("short_clr");
    ready_val = 1'b0;
    step(2);
    rand_row();
    latch(6, 0);
    step(3);
    chk("stall_valid", 64'(m_valid), 1);
    w0 = {m_last, m_data};
    if (exp_q.size() > 0) chk("stall_word0", 64'(w0), 64'(exp_q[0]));
    step(32);
    latch(1, 1);
    step(32);
    latch(2, 1);
    chk("stall_ovf", 64'(ovf), 1);
    chk("stall_hold", 64'({m_last, m_data}), 64'(w0));
    flags("stall");
    ready_val = 1'b1;
    step(60);
    check_q("stall");
    clr();
    rand_row();
    latch(7, 0);
    step(3);
    on_for(70000);
    step(3);
    rand_row();
    latch(0, 0);
    step(60);
    if (got_q.size() == 2 * COLS) begin
      w = got_q[COLS];
      chk("sat_on", 64'(w[ON_LSB +: ONW]), 65535);
    end
    check_q("sat");
    flags("sat");
    rand_row();
    latch(1, 0);
    k = 0;
    while (got_q.size() < 10 && k < 200) begin
      step();
      k++;
    end
    chk("rst_wait_timeout", 64'(k < 200), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 0);
    chk("mid_rst_last", 64'(m_last), 0);
    chk("mid_rst_data", 64'(m_data), 0);
    flags("mid_rst");
    step(2);
    rst = 1'b0;
    model_reset();
    step(2);
    rand_row();
    latch(2, 0);
    step(60);
    chk("post_rst_none", 64'(got_q.size()), 0);
    rand_row();
    latch(3, 0);
    step(60);
    check_q("post_rst");
    flags("post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
